// File: rtl/shift_seq_ctrl_if.sv
// Handshake and serial-side signal bundle for shift_seq_ctrl.
// master drives words and back-pressure; slave is the sequencer.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             stall;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic             busy;
    logic [7:0]       frame_cnt;

    modport master (
        output in_valid, in_data, stall,
        input  in_ready, ser_out, ser_valid, done, busy, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, stall,
        output in_ready, ser_out, ser_valid, done, busy, frame_cnt
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer: loads a word, shifts it out MSB-first,
// honours stall, inserts an idle gap, and counts completed frames.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input logic             clk,
    input logic             rst,
    shift_seq_ctrl_if.slave s
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic [7:0]       frame_cnt, frame_cnt_n;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    // last is the consumption of the final bit; it drives done directly
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;
        frame_cnt_n = frame_cnt;
        last        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (s.in_valid) begin
                    shreg_n   = s.in_data;
                    bit_cnt_n = LAST_BIT;
                    state_n   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!s.stall) begin
                    if (bit_cnt != '0) begin
                        shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt_n = bit_cnt - CW'(1);
                    end else begin
                        last        = 1'b1;
                        frame_cnt_n = frame_cnt + 8'd1;
                        gap_cnt_n   = GAP_INIT;
                        state_n     = (GAP > 0) ? S_GAP : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign s.in_ready  = (state == S_IDLE) && !rst;
    assign s.ser_valid = (state == S_SHIFT) && !rst;
    assign s.busy      = (state != S_IDLE) && !rst;
    assign s.ser_out   = s.ser_valid && shreg[WIDTH-1];
    assign s.done      = last && !rst;
    assign s.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: GAP=2 and GAP=0 instances.
// A negedge monitor logs accepts, consumed bits and done pulses.
module tb_shift_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(8)) m ();
    shift_seq_ctrl_if #(.WIDTH(8)) m0 ();

    shift_seq_ctrl #(.WIDTH(8), .GAP(2)) dut (
        .clk(clk), .rst(rst), .s(m.slave)
    );
    shift_seq_ctrl #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .s(m0.slave)
    );

    int ntests = 0;
    int nfail  = 0;

    int cyc = 0;
    int acc_n = 0, acc_last = 0, acc_prev = 0;
    int done_n = 0, done_last = 0, nbits = 0;
    logic [31:0] bits = '0;
    int acc0_n = 0, acc0_last = 0, acc0_prev = 0;
    int done0_n = 0;
    logic [31:0] bits0 = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m.in_valid && m.in_ready) begin
            acc_n    <= acc_n + 1;
            acc_prev <= acc_last;
            acc_last <= cyc;
        end
        if (m.ser_valid && !m.stall) begin
            bits  <= {bits[30:0], m.ser_out};
            nbits <= nbits + 1;
        end
        if (m.done) begin
            done_n    <= done_n + 1;
            done_last <= cyc;
        end
        if (m0.in_valid && m0.in_ready) begin
            acc0_n    <= acc0_n + 1;
            acc0_prev <= acc0_last;
            acc0_last <= cyc;
        end
        if (m0.ser_valid && !m0.stall)
            bits0 <= {bits0[30:0], m0.ser_out};
        if (m0.done)
            done0_n <= done0_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    int b, bb, a;
    logic [7:0] exp;

    initial begin
        rst = 1'b1;
        m.in_valid = 1'b0;  m.in_data = '0;  m.stall = 1'b0;
        m0.in_valid = 1'b0; m0.in_data = '0; m0.stall = 1'b0;

        // reset values
        tick();
        tick();
        chk("rst_rdy", m.in_ready, 0);
        chk("rst_busy", m.busy, 0);
        chk("rst_sv", m.ser_valid, 0);
        chk("rst_so", m.ser_out, 0);
        chk("rst_done", m.done, 0);
        chk("rst_cnt", m.frame_cnt, 0);
        rst = 1'b0;
        tick();
        chk("idle_rdy", m.in_ready, 1);

        // single frame A5
        b = done_n;
        exp = 8'b1010_0101;
        m.in_valid = 1'b1;
        m.in_data  = 8'hA5;
        tick();
        m.in_valid = 1'b0;
        m.in_data  = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i < 8) chk("t1_bit", m.ser_out, exp[7-i]);
            chk("t1_sv", m.ser_valid, (i < 8));
            chk("t1_done", m.done, (i == 7));
            chk("t1_rdy", m.in_ready, 0);
            chk("t1_busy", m.busy, 1);
            tick();
        end
        #1;
        chk("t1_rdy_end", m.in_ready, 1);
        chk("t1_cnt", m.frame_cnt, 1);
        chk("t1_ndone", done_n - b, 1);
        chk("t1_bits", bits[7:0], 8'hA5);

        // back-to-back FF then 00
        do_reset();
        b = done_n;
        a = acc_n;
        for (int c = 0; c < 60 && (done_n - b) < 2; c++) begin
            m.in_valid = ((acc_n - a) < 2);
            m.in_data  = ((acc_n - a) >= 1) ? 8'h00 : 8'hFF;
            tick();
        end
        m.in_valid = 1'b0;
        #1;
        chk("t2_ndone", done_n - b, 2);
        chk("t2_nacc", acc_n - a, 2);
        chk("t2_space", acc_last - acc_prev, 11);
        chk("t2_bits", bits[15:0], 16'hFF00);
        chk("t2_cnt", m.frame_cnt, 2);

        // stall on 4th bit of C3
        do_reset();
        b  = done_n;
        bb = nbits;
        m.in_valid = 1'b1;
        m.in_data  = 8'hC3;
        tick();
        m.in_valid = 1'b0;
        repeat (3) tick();
        m.stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("t3_so", m.ser_out, 0);
            chk("t3_sv", m.ser_valid, 1);
            chk("t3_done", m.done, 0);
            tick();
        end
        m.stall = 1'b0;
        #1;
        chk("t3_hold", m.ser_out, 0);
        for (int c = 0; c < 30 && done_n == b; c++) tick();
        #1;
        chk("t3_ndone", done_n - b, 1);
        chk("t3_lat", done_last - acc_last, 11);
        chk("t3_bits", bits[7:0], 8'hC3);
        chk("t3_nbits", nbits - bb, 8);
        chk("t3_cnt", m.frame_cnt, 1);

        // reset during 3rd bit of F0
        do_reset();
        b  = done_n;
        bb = nbits;
        m.in_valid = 1'b1;
        m.in_data  = 8'hF0;
        tick();
        m.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t4_sv_rst", m.ser_valid, 0);
        chk("t4_done_rst", m.done, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t4_sv", m.ser_valid, 0);
        chk("t4_busy", m.busy, 0);
        chk("t4_rdy", m.in_ready, 1);
        repeat (12) tick();
        chk("t4_ndone", done_n - b, 0);
        chk("t4_cnt", m.frame_cnt, 0);
        chk("t4_nbits", nbits - bb, 2);

        // 256 frames wrap the counter
        do_reset();
        b = done_n;
        m.in_valid = 1'b1;
        m.in_data  = 8'h01;
        for (int c = 0; c < 3000 && (done_n - b) < 256; c++) tick();
        m.in_valid = 1'b0;
        #1;
        chk("t5_ndone", done_n - b, 256);
        chk("t5_cnt", m.frame_cnt, 0);
        chk("t5_space", acc_last - acc_prev, 11);
        chk("t5_bits", bits[7:0], 8'h01);

        // GAP=0 instance, 81 twice
        b = done0_n;
        a = acc0_n;
        for (int c = 0; c < 60 && (done0_n - b) < 2; c++) begin
            m0.in_valid = ((acc0_n - a) < 2);
            m0.in_data  = 8'h81;
            tick();
        end
        m0.in_valid = 1'b0;
        #1;
        chk("t6_ndone", done0_n - b, 2);
        chk("t6_space", acc0_last - acc0_prev, 9);
        chk("t6_bits", bits0[15:0], 16'h8181);
        chk("t6_cnt", m0.frame_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for a parallel-to-serial shift-register datapath. It accepts a parallel word over a valid/ready handshake, loads it into an internal WIDTH-bit shift register, and shifts it out MSB-first, one bit per clock. It supports a stall input, enforces a programmable idle gap between frames, and counts completed frames. It sits between a word producer and a bit-serial consumer, replacing ad-hoc flip-flop chains driven directly from the bench.

Parameters:
WIDTH, 8, frame length in bits (WIDTH >= 2)
GAP, 1, idle cycles inserted after each frame before in_ready reasserts (GAP >= 0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
in_valid  input  1  producer has a word on in_data
in_data  input  WIDTH  parallel word to serialize
in_ready  output  1  block can accept a word this cycle
stall  input  1  consumer back-pressure; freezes shifting while high
ser_out  output  1  current serial bit (MSB first)
ser_valid  output  1  ser_out carries a frame bit; consumer takes the bit when ser_valid && !stall
done  output  1  one-cycle pulse when the last bit of a frame is consumed
busy  output  1  high in SHIFT and GAP
frame_cnt  output  8  count of completed frames, wraps 255 -> 0

Behaviour:
- States: IDLE, SHIFT, GAP. Registers: shreg[WIDTH], bit_cnt (clog2(WIDTH) bits), gap_cnt (clog2(GAP+1) bits, min 1), frame_cnt[8].
- Reset (rst high at a rising edge): state=IDLE, shreg=0, bit_cnt=0, gap_cnt=0, frame_cnt=0. While rst is high, in_ready=0, ser_valid=0, ser_out=0, done=0 and busy=0. Reset mid-frame aborts the frame. No done is issued and frame_cnt is unchanged from 0.
- in_ready = (state==IDLE) && !rst. ser_valid = busy = meaning per state below. ser_out = shreg[WIDTH-1] when state==SHIFT, else 0.
- IDLE: if in_valid && in_ready at edge k, then shreg<=in_data, bit_cnt<=WIDTH-1, state<=SHIFT. First bit (in_data[WIDTH-1]) is on ser_out in cycle k+1. in_data is ignored in all states other than IDLE.
- SHIFT: ser_valid=1, busy=1.
  - If stall=1: shreg, bit_cnt and state hold, and ser_out holds.
  - If stall=0 and bit_cnt!=0: shreg<=shreg<<1 (zero fill) and bit_cnt<=bit_cnt-1.
  - If stall=0 and bit_cnt==0: done=1 this cycle (combinational on state/bit_cnt/stall) and frame_cnt<=frame_cnt+1 (mod 256). Next state is GAP with gap_cnt<=GAP-1 if GAP>0, else IDLE.
- Latency: with no stall, bits occupy cycles k+1..k+WIDTH and done is high in cycle k+WIDTH. Each stall cycle in SHIFT adds exactly one cycle.
- GAP: ser_valid=0, busy=1, stall is ignored. Decrement gap_cnt each cycle and go to IDLE after the cycle in which gap_cnt==0. GAP lasts exactly GAP cycles.
- Back-to-back: the minimum accept-to-accept spacing is WIDTH+GAP+1 cycles.
- stall in IDLE or GAP has no effect. in_valid held high in SHIFT or GAP is not captured; the word is taken at the first IDLE cycle.
- done and frame_cnt update only on consumption of the last bit; a stall on the last bit delays both.

Test Plan:
1. WIDTH=8, GAP=2. Reset 2 cycles, then present 8'hA5 with in_valid for 1 cycle -> ser_out over the next 8 cycles = 1,0,1,0,0,1,0,1 with ser_valid=1; done high on the 8th bit only; frame_cnt=1; in_ready=0 for 10 cycles, then 1.
2. Hold in_valid high with 8'hFF, then switch to 8'h00 immediately after acceptance -> frames accepted 11 cycles apart; second frame outputs eight 0s; frame_cnt=2; exactly 2 done pulses.
3. Send 8'hC3 and assert stall for 3 cycles while the 4th bit (0) is on ser_out -> that bit holds for 4 cycles; sequence 1,1,0,0,0,0,1,1 as consumed; done 11 cycles after acceptance.
4. Send 8'hF0 and assert rst during the 3rd bit -> ser_valid=0 and state IDLE from the next cycle; no done; frame_cnt=0; in_ready=1 one cycle after rst drops.
5. Stream 256 frames of 8'h01 -> frame_cnt wraps to 0 after the 256th done, with no missed done pulses.
6. GAP=0 build, send 8'h81 twice with in_valid held -> acceptances 9 cycles apart; ser_out 1,0,0,0,0,0,0,1 twice; frame_cnt=2.
